// File: rtl/button_pkg.sv
// Shared types and helpers for the paddle button conditioner.
//   btn_state_e : per-channel debounce FSM state
//   cnt_width() : width of a counter that must hold values 0..max_val
//   Default timing constants for a 25 MHz system clock.
package button_pkg;

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } btn_state_e;

  localparam int unsigned DEBOUNCE_10MS_25MHZ   = 250000;
  localparam int unsigned REPEAT_DELAY_DEFAULT  = 12500000;
  localparam int unsigned REPEAT_PERIOD_DEFAULT = 2500000;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw paddle buttons and the game logic.
//   BTN_UP_RAW / BTN_DOWN_RAW     : raw asynchronous button inputs
//   BTN_UP / BTN_DOWN             : debounced levels, 1 = pressed
//   BTN_UP_PRESS / BTN_DOWN_PRESS : one-cycle press pulses
// master: the button/board side; slave: the conditioner.
interface button_conditioner_if;
  logic BTN_UP_RAW;
  logic BTN_DOWN_RAW;
  logic BTN_UP;
  logic BTN_DOWN;
  logic BTN_UP_PRESS;
  logic BTN_DOWN_PRESS;

  modport master (
    output BTN_UP_RAW, BTN_DOWN_RAW,
    input  BTN_UP, BTN_DOWN, BTN_UP_PRESS, BTN_DOWN_PRESS
  );

  modport slave (
    input  BTN_UP_RAW, BTN_DOWN_RAW,
    output BTN_UP, BTN_DOWN, BTN_UP_PRESS, BTN_DOWN_PRESS
  );
endinterface

// File: rtl/button_debounce.sv
// Single button channel: synchroniser, polarity correction, debounce FSM with dwell
// counter, and (with BUTTON_AUTOREPEAT_EN defined) auto-repeat press pulses.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   raw   : raw asynchronous button input
//   level : debounced level, 1 = pressed
//   press : one-cycle pulse on accepted press (plus repeats when enabled)
module button_debounce import button_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned ACTIVE_LOW      = 0
`ifdef BUTTON_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  // Raw level of a released button; the synchroniser resets to it.
  localparam logic RelLvl = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  btn_state_e             state_q;
  logic [CntW-1:0]        cnt_q;
  logic                   level_q;
  logic                   press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RelLvl}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ RelLvl;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW = cnt_width(RptMax);
  localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

  logic [RptW-1:0] rpt_q;
  logic            rpt_first_q;  // still waiting out the initial delay
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StReleased;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      press_q <= 1'b0;
      unique case (state_q)
        StReleased: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // Single-cycle dwell: accept on the edge the change is seen.
              state_q <= StPressed;
              level_q <= 1'b1;
              press_q <= 1'b1;
              cnt_q   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
              rpt_q       <= '0;
              rpt_first_q <= 1'b1;
`endif
            end else begin
              state_q <= StPressWait;
              cnt_q   <= CntW'(1);
            end
          end
        end
        StPressWait: begin
          if (!s) begin
            state_q <= StReleased;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StPressed;
            level_q <= 1'b1;
            press_q <= 1'b1;
            cnt_q   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StPressed: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= StReleased;
              level_q <= 1'b0;
              cnt_q   <= '0;
            end else begin
              state_q <= StReleaseWait;
              cnt_q   <= CntW'(1);
            end
`ifdef BUTTON_AUTOREPEAT_EN
            rpt_q <= '0;
          end else if (rpt_q == (rpt_first_q ? DelayLast : PeriodLast)) begin
            press_q     <= 1'b1;
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
          end else begin
            rpt_q <= rpt_q + RptW'(1);
`endif
          end
        end
        StReleaseWait: begin
          if (s) begin
            // Bounce back to pressed: level never dropped, so no new initial pulse.
            state_q <= StPressed;
            cnt_q   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
`endif
          end else if (cnt_q == CntLast) begin
            state_q <= StReleased;
            level_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StReleased;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Paddle button conditioner: two independent debounced channels (up, down) feeding
// topEntity. Each produces a clean level and a one-cycle press pulse.
//   CLK_25MHZ : system pixel clock
//   RESET     : asynchronous active-high reset
//   bus       : button bundle (raw inputs in, levels and pulses out)
// Define BUTTON_AUTOREPEAT_EN to add auto-repeat press pulses while held.
module button_conditioner import button_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned ACTIVE_LOW      = 0
`ifdef BUTTON_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
`endif
) (
  input logic                 CLK_25MHZ,
  input logic                 RESET,
  button_conditioner_if.slave bus
);

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) u_up (
    .clk   (CLK_25MHZ),
    .rst   (RESET),
    .raw   (bus.BTN_UP_RAW),
    .level (bus.BTN_UP),
    .press (bus.BTN_UP_PRESS)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) u_down (
    .clk   (CLK_25MHZ),
    .rst   (RESET),
    .raw   (bus.BTN_DOWN_RAW),
    .level (bus.BTN_DOWN),
    .press (bus.BTN_DOWN_PRESS)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
// A raw change made just after clock edge 0 shows on the outputs after edge 10.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  button_conditioner_if hi_if ();
  button_conditioner_if lo_if ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (8),
    .SYNC_STAGES     (2),
    .ACTIVE_LOW      (0)
  ) dut (
    .CLK_25MHZ (clk),
    .RESET     (rst),
    .bus       (hi_if.slave)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES (8),
    .SYNC_STAGES     (2),
    .ACTIVE_LOW      (1)
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5)
`endif
  ) dut_al (
    .CLK_25MHZ (clk),
    .RESET     (rst),
    .bus       (lo_if.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    hi_if.BTN_UP_RAW   = 1'b0;
    hi_if.BTN_DOWN_RAW = 1'b0;
    lo_if.BTN_UP_RAW   = 1'b1;
    lo_if.BTN_DOWN_RAW = 1'b1;
    rst = 1'b1;
    tick(2);
    vectors++;
    if ({hi_if.BTN_UP, hi_if.BTN_DOWN, hi_if.BTN_UP_PRESS, hi_if.BTN_DOWN_PRESS} !== 4'b0) begin
      errors++;
      $display("FAIL reset_hi outputs got %b want 0000", {hi_if.BTN_UP, hi_if.BTN_DOWN,
               hi_if.BTN_UP_PRESS, hi_if.BTN_DOWN_PRESS});
    end
    vectors++;
    if ({lo_if.BTN_UP, lo_if.BTN_DOWN, lo_if.BTN_UP_PRESS, lo_if.BTN_DOWN_PRESS} !== 4'b0) begin
      errors++;
      $display("FAIL reset_lo outputs got %b want 0000", {lo_if.BTN_UP, lo_if.BTN_DOWN,
               lo_if.BTN_UP_PRESS, lo_if.BTN_DOWN_PRESS});
    end
    rst = 1'b0;
    tick(14);
    // Released active-low buttons (raw=1) must stay idle after reset.
    vectors++;
    if ({lo_if.BTN_UP, lo_if.BTN_DOWN} !== 2'b00) begin
      errors++;
      $display("FAIL idle_active_low levels got %b want 00", {lo_if.BTN_UP, lo_if.BTN_DOWN});
    end
  endtask

  task automatic test_clean_press();
    int rise = -1, pcyc = -1, npulse = 0;
    bit dn_seen = 1'b0;
    hi_if.BTN_UP_RAW = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick(1);
      if (hi_if.BTN_UP && rise < 0) rise = c;
      if (hi_if.BTN_UP_PRESS) begin
        npulse++;
        if (pcyc < 0) pcyc = c;
      end
      if (hi_if.BTN_DOWN || hi_if.BTN_DOWN_PRESS) dn_seen = 1'b1;
    end
    vectors++;
    if (rise !== 10) begin errors++; $display("FAIL clean_rise got %0d want 10", rise); end
    vectors++;
    if (pcyc !== 10) begin errors++; $display("FAIL clean_pulse_cycle got %0d want 10", pcyc); end
    vectors++;
    if (npulse !== 1) begin errors++; $display("FAIL clean_pulse_width got %0d want 1", npulse); end
    vectors++;
    if (hi_if.BTN_UP !== 1'b1) begin
      errors++; $display("FAIL clean_held got %b want 1", hi_if.BTN_UP);
    end
    vectors++;
    if (dn_seen !== 1'b0) begin errors++; $display("FAIL clean_down_idle got 1 want 0"); end
  endtask

  task automatic test_release();
    int fall = -1, npulse = 0;
    bit low_seen = 1'b0;
    // 5-cycle release glitch must be swallowed.
    hi_if.BTN_UP_RAW = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 6) hi_if.BTN_UP_RAW = 1'b1;
      tick(1);
      if (!hi_if.BTN_UP) low_seen = 1'b1;
      if (hi_if.BTN_UP_PRESS) npulse++;
    end
    vectors++;
    if (low_seen !== 1'b0) begin errors++; $display("FAIL glitch_level got drop want held"); end
    vectors++;
    if (npulse !== 0) begin errors++; $display("FAIL glitch_pulse got %0d want 0", npulse); end
    npulse = 0;
    hi_if.BTN_UP_RAW = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (!hi_if.BTN_UP && fall < 0) fall = c;
      if (hi_if.BTN_UP_PRESS) npulse++;
    end
    vectors++;
    if (fall !== 10) begin errors++; $display("FAIL release_fall got %0d want 10", fall); end
    vectors++;
    if (npulse !== 0) begin errors++; $display("FAIL release_pulse got %0d want 0", npulse); end
  endtask

  task automatic test_bounce();
    int rise = -1, npulse = 0;
    bit early = 1'b0;
    for (int c = 0; c < 30; c++) begin
      hi_if.BTN_UP_RAW = ((c / 3) % 2) == 0;
      tick(1);
      if (hi_if.BTN_UP || hi_if.BTN_UP_PRESS) early = 1'b1;
    end
    hi_if.BTN_UP_RAW = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (hi_if.BTN_UP && rise < 0) rise = c;
      if (hi_if.BTN_UP_PRESS) npulse++;
    end
    vectors++;
    if (early !== 1'b0) begin errors++; $display("FAIL bounce_early got output want none"); end
    vectors++;
    if (rise !== 10) begin errors++; $display("FAIL bounce_rise got %0d want 10", rise); end
    vectors++;
    if (npulse !== 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", npulse); end
    hi_if.BTN_UP_RAW = 1'b0;
    tick(15);
  endtask

  task automatic test_simultaneous();
    int up_c = -1, dn_c = -1;
    hi_if.BTN_UP_RAW   = 1'b1;
    hi_if.BTN_DOWN_RAW = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (hi_if.BTN_UP_PRESS && up_c < 0) up_c = c;
      if (hi_if.BTN_DOWN_PRESS && dn_c < 0) dn_c = c;
    end
    vectors++;
    if (up_c !== 10) begin errors++; $display("FAIL simul_up got %0d want 10", up_c); end
    vectors++;
    if (dn_c !== 10) begin errors++; $display("FAIL simul_down got %0d want 10", dn_c); end
    hi_if.BTN_UP_RAW   = 1'b0;
    hi_if.BTN_DOWN_RAW = 1'b0;
    tick(15);
    vectors++;
    if ({hi_if.BTN_UP, hi_if.BTN_DOWN} !== 2'b00) begin
      errors++; $display("FAIL simul_release got %b want 00", {hi_if.BTN_UP, hi_if.BTN_DOWN});
    end
  endtask

  task automatic test_reset_mid_dwell();
    int pcyc = -1;
    hi_if.BTN_UP_RAW = 1'b1;
    tick(6);
    rst = 1'b1;
    #1;
    vectors++;
    if ({hi_if.BTN_UP, hi_if.BTN_UP_PRESS} !== 2'b00) begin
      errors++; $display("FAIL dwell_reset got %b want 00", {hi_if.BTN_UP, hi_if.BTN_UP_PRESS});
    end
    tick(3);
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (hi_if.BTN_UP_PRESS && pcyc < 0) pcyc = c;
    end
    vectors++;
    if (pcyc !== 10) begin errors++; $display("FAIL dwell_pulse got %0d want 10", pcyc); end
    vectors++;
    if (hi_if.BTN_UP !== 1'b1) begin
      errors++; $display("FAIL dwell_level got %b want 1", hi_if.BTN_UP);
    end
    // Reset while pressed: level must drop with no clock edge in between.
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (hi_if.BTN_UP !== 1'b0) begin
      errors++; $display("FAIL async_reset_level got %b want 0", hi_if.BTN_UP);
    end
    tick(2);
    rst = 1'b0;
    hi_if.BTN_UP_RAW = 1'b0;
    tick(15);
  endtask

  task automatic test_active_low();
    bit exp;
    int npulse = 0;
    lo_if.BTN_UP_RAW = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      tick(1);
      exp = (c == 10);
`ifdef BUTTON_AUTOREPEAT_EN
      exp = exp || (c >= 30 && ((c - 30) % 5) == 0);
`endif
      vectors++;
      if (lo_if.BTN_UP_PRESS !== exp) begin
        errors++;
        $display("FAIL al_pulse cycle %0d got %b want %b", c, lo_if.BTN_UP_PRESS, exp);
      end
    end
    vectors++;
    if (lo_if.BTN_UP !== 1'b1) begin
      errors++; $display("FAIL al_level got %b want 1", lo_if.BTN_UP);
    end
    lo_if.BTN_UP_RAW = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (lo_if.BTN_UP_PRESS) npulse++;
    end
    vectors++;
    if (npulse !== 0) begin errors++; $display("FAIL al_release_pulse got %0d want 0", npulse); end
    vectors++;
    if ({lo_if.BTN_UP, lo_if.BTN_DOWN} !== 2'b00) begin
      errors++; $display("FAIL al_release got %b want 00", {lo_if.BTN_UP, lo_if.BTN_DOWN});
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_dwell();
    test_active_low();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
